// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath blocks: fetch FSM
// encoding and architectural constants.
package mips_pkg;

    localparam int INST_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register plus the instruction-fetch handshake: request, wait for data,
// then hold the instruction for decode until accepted.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       npc,
    output logic [31:0]       pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    output logic              misalign,
    output logic [CNT_W-1:0]  fetch_cnt
);

    fetch_state_e state_q, state_d;
    logic         req_q;
    logic         fire;

    // The request is a flop rather than a decode of FETCH so it is low in the
    // first cycle out of reset without any path from rst to the output.
    assign imem_req   = req_q;
    assign imem_addr  = pc;
    assign inst_valid = (state_q == HOLD);
    assign fire       = (state_q == HOLD) && inst_ready;

    // NOTE: every output of this block is assigned a default first so the
    // case statement cannot leave a path that infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (req_q && imem_gnt) state_d = WAIT;
            WAIT:  if (imem_rvalid)       state_d = HOLD;
            HOLD:  if (inst_ready)        state_d = (npc[1:0] == 2'b00) ? FETCH : HALT;
            HALT:                         state_d = HALT;
            default:                      state_d = FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            req_q     <= 1'b0;
            pc        <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            misalign  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == FETCH);

            if (state_q == WAIT && imem_rvalid) begin
                inst    <= imem_rdata;
                inst_pc <= pc;
            end

            // npc only matters in the fire cycle; a misaligned target freezes pc.
            if (fire) begin
                fetch_cnt <= fetch_cnt + 1'b1;
                if (npc[1:0] == 2'b00) begin
                    pc <= npc;
                end else begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a table-driven stream after reset plus
// hand-written sequences for stalls, misalignment, reset and wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .misalign    (misalign),
        .fetch_cnt   (fetch_cnt)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] d,
                                input logic rd, input logic [31:0] n,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] eip,
                                input logic [31:0] ec);
        vec_t v;
        v.gnt = g;   v.rvalid = rv; v.rdata = d; v.ready = rd; v.npc = n;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_inst = ei; v.e_ipc = eip; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; npc = '0;
    endtask

    // Leaves the bench in the first cycle after the reset edge.
    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // From FETCH with the request up: grant, return data, fire with next_pc.
    task automatic do_fetch(input logic [31:0] data, input logic [31:0] next_pc);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data;
        step();
        imem_rvalid = 1'b0; inst_ready = 1'b1; npc = next_pc;
        step();
        idle_inputs();
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 32'h0,         1, 32'h0,    0, 32'h3000, 0, 32'h0,         32'h0,    0);
        tbl[1]  = mk(1, 0, 32'h0,         1, 32'h0,    1, 32'h3000, 0, 32'h0,         32'h0,    0);
        tbl[2]  = mk(0, 1, 32'hA000_0000, 1, 32'h0,    0, 32'h3000, 0, 32'h0,         32'h0,    0);
        tbl[3]  = mk(0, 0, 32'h0,         1, 32'h3004, 0, 32'h3000, 1, 32'hA000_0000, 32'h3000, 0);
        tbl[4]  = mk(1, 0, 32'h0,         1, 32'h0,    1, 32'h3004, 0, 32'hA000_0000, 32'h3000, 1);
        tbl[5]  = mk(0, 1, 32'hA000_0001, 1, 32'h0,    0, 32'h3004, 0, 32'hA000_0000, 32'h3000, 1);
        tbl[6]  = mk(0, 0, 32'h0,         1, 32'h3008, 0, 32'h3004, 1, 32'hA000_0001, 32'h3004, 1);
        tbl[7]  = mk(1, 0, 32'h0,         1, 32'h0,    1, 32'h3008, 0, 32'hA000_0001, 32'h3004, 2);
        tbl[8]  = mk(0, 1, 32'hA000_0002, 1, 32'h0,    0, 32'h3008, 0, 32'hA000_0001, 32'h3004, 2);
        tbl[9]  = mk(0, 0, 32'h0,         1, 32'h300C, 0, 32'h3008, 1, 32'hA000_0002, 32'h3008, 2);
        tbl[10] = mk(0, 0, 32'h0,         0, 32'h0,    1, 32'h300C, 0, 32'hA000_0002, 32'h3008, 3);

        // Reset then back-to-back stream at one instruction per three cycles.
        reset_dut();
        check("reset_misalign", misalign, 0);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("stream%0d_req", i),   imem_req,   tbl[i].e_req);
            check($sformatf("stream%0d_addr", i),  imem_addr,  tbl[i].e_addr);
            check($sformatf("stream%0d_pc", i),    pc,         tbl[i].e_addr);
            check($sformatf("stream%0d_valid", i), inst_valid, tbl[i].e_valid);
            check($sformatf("stream%0d_inst", i),  inst,       tbl[i].e_inst);
            check($sformatf("stream%0d_ipc", i),   inst_pc,    tbl[i].e_ipc);
            check($sformatf("stream%0d_cnt", i),   fetch_cnt,  tbl[i].e_cnt);
            imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
            inst_ready = tbl[i].ready; npc = tbl[i].npc;
            step();
        end

        // Memory backpressure: grant withheld 4 cycles, data 2 cycles after grant.
        reset_dut();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_req%0d", i),  imem_req,  1);
            check($sformatf("bp_addr%0d", i), imem_addr, 32'h3000);
            step();
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("bp_wait_req%0d", i),   imem_req,   0);
            check($sformatf("bp_wait_valid%0d", i), inst_valid, 0);
            step();
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h1000_0003;
        check("bp_rv_cycle_valid", inst_valid, 0);
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        check("bp_valid", inst_valid, 1);
        check("bp_inst",  inst,       32'h1000_0003);
        check("bp_ipc",   inst_pc,    32'h3000);

        // Decode stall with npc toggling, then fire on the branch target.
        for (int i = 0; i < 5; i++) begin
            npc = (i % 2 == 0) ? 32'h0000_5002 : 32'h0000_7000;
            check($sformatf("stall%0d_valid", i), inst_valid, 1);
            check($sformatf("stall%0d_inst", i),  inst,       32'h1000_0003);
            check($sformatf("stall%0d_ipc", i),   inst_pc,    32'h3000);
            check($sformatf("stall%0d_req", i),   imem_req,   0);
            check($sformatf("stall%0d_pc", i),    pc,         32'h3000);
            step();
        end
        npc = 32'h3010; inst_ready = 1'b1;
        step();
        idle_inputs();
        check("stall_fire_addr", imem_addr, 32'h3010);
        check("stall_fire_req",  imem_req,  1);
        check("stall_fire_cnt",  fetch_cnt, 1);
        check("stall_fire_mis",  misalign,  0);

        // Misaligned redirect halts until reset.
        reset_dut();
        step();
        do_fetch(32'h2222_0000, 32'h3006);
        check("mis_flag",  misalign,   1);
        check("mis_pc",    pc,         32'h3000);
        check("mis_cnt",   fetch_cnt,  1);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1; npc = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halt%0d_req", i),   imem_req,   0);
            check($sformatf("halt%0d_valid", i), inst_valid, 0);
            check($sformatf("halt%0d_mis", i),   misalign,   1);
            step();
        end
        reset_dut();
        check("halt_rst_mis", misalign,  0);
        check("halt_rst_cnt", fetch_cnt, 0);

        // Reset while in WAIT; the late response is dropped.
        step();
        do_fetch(32'h1111_1111, 32'h3004);
        check("rmf_cnt_before", fetch_cnt, 1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        check("rmf_req0",  imem_req,   0);
        check("rmf_pc",    pc,         32'h3000);
        check("rmf_cnt",   fetch_cnt,  0);
        step();
        imem_rvalid = 1'b0;
        check("rmf_req1",  imem_req,   1);
        check("rmf_addr",  imem_addr,  32'h3000);
        check("rmf_valid", inst_valid, 0);
        check("rmf_inst",  inst,       0);
        step();
        check("rmf_still_fetch", imem_req, 1);

        // PC wrap through the top of the address space.
        do_fetch(32'h3333_3333, 32'hFFFF_FFFC);
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h4444_4444, 32'h0000_0000);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req",  imem_req,  1);
        check("wrap_mis",  misalign,  0);
        check("wrap_ipc",  inst_pc,   32'hFFFF_FFFC);
        check("wrap_cnt",  fetch_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
